// File: rtl/sigma_delta_pkg.sv
// Shared constants and helpers for the sigma-delta CIC decimator.
// Sizes the modular accumulators and clamps wide signed values into a narrower range.
package sigma_delta_pkg;

  localparam int CIC_ORDER = 3;

  // Each integrator stage grows by log2(R) bits; two extra bits cover the +/-1 input and sign.
  function automatic int cic_acc_width(input int order, input int decim_log2);
    return order * decim_log2 + 2;
  endfunction

  function automatic logic signed [63:0] sat_signed(
    input logic signed [63:0] value,
    input int                 in_w,
    input int                 out_w
  );
    logic signed [63:0] maxVal;
    logic signed [63:0] minVal;
    maxVal = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    minVal = -(64'sd1 <<< (out_w - 1));
    if (in_w <= out_w)
      return value;
    else if (value > maxVal)
      return maxVal;
    else if (value < minVal)
      return minVal;
    else
      return value;
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// One wrapping integrator stage of the CIC chain; the sum is allowed to overflow,
// which is what makes the later comb differences come out exact.
module cic_integrator
  import sigma_delta_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] in,
  output logic signed [ACC_W-1:0] acc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      acc <= '0;
    else if (en)
      acc <= acc + in;
  end

endmodule

// File: rtl/sigma_delta_cic_decimator.sv
// Third-order CIC decimator: 1-bit sigma-delta stream in, signed WIDTH-bit PCM out
// once every 2^DECIM_LOG2 accepted bits, with a one-cycle valid pulse after warm-up.
module sigma_delta_cic_decimator
  import sigma_delta_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DECIM_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sdIn,
  output logic signed [WIDTH-1:0] out,
  output logic                    outValid
);

  localparam int ACC_W = cic_acc_width(CIC_ORDER, DECIM_LOG2);
  localparam int SHIFT = CIC_ORDER * DECIM_LOG2 - (WIDTH - 1);

  if ((CIC_ORDER * DECIM_LOG2 < WIDTH - 1) || (DECIM_LOG2 < 1) || (ACC_W > 64)) begin : g_badParams
    $error("sigma_delta_cic_decimator: DECIM_LOG2 too small for WIDTH or out of range");
  end

  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] w_i1;
  logic signed [ACC_W-1:0] w_i2;
  logic signed [ACC_W-1:0] w_i3;
  logic signed [ACC_W-1:0] w_c1;
  logic signed [ACC_W-1:0] w_c2;
  logic signed [ACC_W-1:0] w_c3;
  logic signed [ACC_W-1:0] w_y;

  logic signed [ACC_W-1:0] r_d1;
  logic signed [ACC_W-1:0] r_d2;
  logic signed [ACC_W-1:0] r_d3;
  logic [DECIM_LOG2-1:0]   r_cnt;
  logic                    r_tick;
  logic [1:0]              r_warm;

  assign w_x = sdIn ? ACC_W'(1) : '1;

  // Stages 2 and 3 integrate the pre-edge value of the previous stage.
  cic_integrator #(.ACC_W(ACC_W)) u_int1 (.clk(clk), .rst(rst), .en(en), .in(w_x),  .acc(w_i1));
  cic_integrator #(.ACC_W(ACC_W)) u_int2 (.clk(clk), .rst(rst), .en(en), .in(w_i1), .acc(w_i2));
  cic_integrator #(.ACC_W(ACC_W)) u_int3 (.clk(clk), .rst(rst), .en(en), .in(w_i2), .acc(w_i3));

  assign w_c1 = w_i3 - r_d1;
  assign w_c2 = w_c1 - r_d2;
  assign w_c3 = w_c2 - r_d3;
  assign w_y  = w_c3 >>> SHIFT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= en && (&r_cnt);
      if (en)
        r_cnt <= r_cnt + DECIM_LOG2'(1);
    end
  end

  // The comb runs only in the tick cycle; the first two results flush the zeroed delays.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d1     <= '0;
      r_d2     <= '0;
      r_d3     <= '0;
      r_warm   <= '0;
      out      <= '0;
      outValid <= 1'b0;
    end else if (r_tick) begin
      r_d1 <= w_i3;
      r_d2 <= w_c1;
      r_d3 <= w_c2;
      out  <= WIDTH'(sat_signed(64'(w_y), ACC_W, WIDTH));
      if (r_warm == 2'd2) begin
        outValid <= 1'b1;
      end else begin
        outValid <= 1'b0;
        r_warm   <= r_warm + 2'd1;
      end
    end else begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sigma_delta_cic_decimator.sv
// Directed bench for the CIC decimator: full-scale, zero and half density streams,
// gated strobes, idle holds and asynchronous reset, all against hand-derived values.
module tb_sigma_delta_cic_decimator;

  localparam int WIDTH      = 16;
  localparam int DECIM_LOG2 = 6;

  logic                    clk  = 1'b0;
  logic                    rst  = 1'b0;
  logic                    en   = 1'b0;
  logic                    sdIn = 1'b0;
  logic signed [WIDTH-1:0] out;
  logic                    outValid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sigma_delta_cic_decimator #(
    .WIDTH(WIDTH),
    .DECIM_LOG2(DECIM_LOG2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sdIn(sdIn),
    .out(out),
    .outValid(outValid)
  );

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic resetDut();
    en  = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Runs a repeating bit pattern (bit 0 first) with en high on every enPeriod-th cycle.
  // Warm-up outputs land one and two output periods before the first valid pulse.
  task automatic applyStimulus(
    input string    tag,
    input bit [3:0] pattern,
    input int       patLen,
    input int       enPeriod,
    input int       cycles,
    input int       expFirst,
    input int       expSpacing,
    input longint   expVal,
    input bit       checkWarm,
    input longint   warm1,
    input longint   warm2
  );
    int samples    = 0;
    int pulses     = 0;
    int lastPulse  = 0;
    int firstPulse = -1;
    int expCount;
    bit nextEn;
    for (int cyc = 1; cyc <= cycles; cyc++) begin
      nextEn = ((cyc % enPeriod) == 0);
      en     = nextEn;
      sdIn   = pattern[samples % patLen];
      @(posedge clk);
      #1;
      if (nextEn)
        samples++;
      if (checkWarm && (cyc == expFirst - 2 * expSpacing)) begin
        checkOutput({tag, " warm1 out"}, out, warm1);
        checkOutput({tag, " warm1 valid"}, outValid, 0);
      end
      if (checkWarm && (cyc == expFirst - expSpacing)) begin
        checkOutput({tag, " warm2 out"}, out, warm2);
        checkOutput({tag, " warm2 valid"}, outValid, 0);
      end
      if (outValid) begin
        pulses++;
        checkOutput({tag, " value"}, out, expVal);
        if (firstPulse < 0) begin
          firstPulse = cyc;
          checkOutput({tag, " first valid cycle"}, cyc, expFirst);
        end else begin
          checkOutput({tag, " valid spacing"}, cyc - lastPulse, expSpacing);
        end
        lastPulse = cyc;
      end
    end
    en = 1'b0;
    expCount = (cycles >= expFirst) ? ((cycles - expFirst) / expSpacing + 1) : 0;
    checkOutput({tag, " pulse count"}, pulses, expCount);
  endtask

  initial begin
    int pulses;

    $display("[TB] reset and idle");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out", out, 0);
    checkOutput("reset valid", outValid, 0);
    rst    = 1'b1;
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (outValid) pulses++;
    end
    checkOutput("idle pulses", pulses, 0);
    checkOutput("idle out", out, 0);

    // C(64,3)>>>3 = 5208 and (C(128,3) - 3*C(64,3))>>>3 = 27048 during warm-up.
    $display("[TB] full scale ones");
    applyStimulus("ones", 4'b1111, 1, 1, 449, 193, 64, 32767, 1'b1, 5208, 27048);

    $display("[TB] full scale zeros");
    resetDut();
    applyStimulus("zeros", 4'b0000, 1, 1, 449, 193, 64, -32768, 1'b1, -5208, -27048);

    $display("[TB] zero density");
    resetDut();
    applyStimulus("alt", 4'b0001, 2, 1, 449, 193, 64, 0, 1'b0, 0, 0);

    $display("[TB] half density with wrap");
    resetDut();
    applyStimulus("half", 4'b0111, 4, 1, 1473, 193, 64, 16384, 1'b0, 0, 0);

    $display("[TB] gated strobe");
    resetDut();
    applyStimulus("gated", 4'b1111, 1, 4, 1537, 769, 256, 32767, 1'b1, 5208, 27048);
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (outValid) pulses++;
    end
    checkOutput("hold pulses", pulses, 0);
    checkOutput("hold out", out, 32767);
    applyStimulus("resume", 4'b1111, 1, 4, 513, 257, 256, 32767, 1'b0, 0, 0);

    $display("[TB] reset mid-block");
    resetDut();
    applyStimulus("pre-reset", 4'b1111, 1, 1, 100, 193, 64, 32767, 1'b0, 0, 0);
    checkOutput("pre-reset out", out, 5208);
    rst = 1'b0;
    #1;
    checkOutput("async reset out", out, 0);
    checkOutput("async reset valid", outValid, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus("post-reset", 4'b0000, 1, 1, 257, 193, 64, -32768, 1'b1, -5208, -27048);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
